// File: rtl/fwd_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// fwd_hazard_ctrl
//
// Forwarding and load-use hazard controller for the pipelined SAD datapath.
// Lives in ID and drives the EX-stage 3-to-1 operand mux selects, registered
// at the ID/EX boundary. A private shadow pipeline records the destination
// register, register-write and load flags of the instructions now in EX and
// MEM, so the controller needs no feedback from the datapath itself.
//
// A load followed immediately by a consumer of its destination raises Stall
// for exactly one cycle. During that cycle a bubble enters EX. The held
// consumer then picks the load result up from MEM/WB.
//
// Optional build macro:
//   FWD_STALL_CNT_EN - adds the StallCnt output, a saturating 16-bit count of
//                      stall cycles since reset. When the macro is undefined
//                      the port and its counter are not generated.
// -----------------------------------------------------------------------------
module fwd_hazard_ctrl #(
    parameter int REG_W = 5
) (
    input  logic             Clk,
    input  logic             Rst,         // asynchronous, active-low
    input  logic             IdValid,
    input  logic [REG_W-1:0] IdRs,
    input  logic [REG_W-1:0] IdRt,
    input  logic [REG_W-1:0] IdDst,
    input  logic             IdRegWrite,
    input  logic             IdMemRead,
    input  logic             Flush,
    output logic [2:0]       SelA,
    output logic [2:0]       SelB,
    output logic             Stall
`ifdef FWD_STALL_CNT_EN
    ,
    output logic [15:0]      StallCnt
`endif
);

    // Operand mux select encoding as wired in the EX stage.
    typedef enum logic [2:0] {
        SEL_RF    = 3'd0,  // register-file value (inB)
        SEL_EXMEM = 3'd1,  // EX/MEM ALU result (inA)
        SEL_MEMWB = 3'd2   // MEM/WB write-back data (inC)
    } sel_e;

    // RUN: normal issue. STALL: the one bubble cycle after a load-use hit.
    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_e;

    // Register $0 is hard-wired to zero, so it is never a forwarding source.
    localparam logic [REG_W-1:0] REG_ZERO = '0;

    state_e           state_q, state_d;

    // Shadow of the instruction in EX.
    logic [REG_W-1:0] ex_dst_q, ex_dst_d;
    logic             ex_rw_q,  ex_rw_d;
    logic             ex_mr_q,  ex_mr_d;

    // Shadow of the instruction in MEM. Whether it was a load no longer
    // matters there, because its data is already available for forwarding.
    logic [REG_W-1:0] mem_dst_q, mem_dst_d;
    logic             mem_rw_q,  mem_rw_d;

    sel_e             sel_a_q, sel_a_d;
    sel_e             sel_b_q, sel_b_d;

    logic             stall;
    logic             id_bubble;

    // Picks the youngest in-flight producer of src. EX beats MEM because the
    // EX instruction is the more recent writer of the same register.
    function automatic sel_e fwd_sel(
        input logic             ex_rw,
        input logic [REG_W-1:0] ex_dst,
        input logic             mem_rw,
        input logic [REG_W-1:0] mem_dst,
        input logic [REG_W-1:0] src
    );
        sel_e sel;
        sel = SEL_RF;
        if (ex_rw && (ex_dst != REG_ZERO) && (ex_dst == src)) begin
            sel = SEL_EXMEM;
        end else if (mem_rw && (mem_dst != REG_ZERO) && (mem_dst == src)) begin
            sel = SEL_MEMWB;
        end
        return sel;
    endfunction

    // Hazard detection, shadow-pipe next state, select computation and FSM.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path
        //       through this block leaves a value unassigned and no latch is
        //       inferred.
        state_d   = state_q;
        stall     = 1'b0;
        id_bubble = 1'b0;
        ex_dst_d  = '0;
        ex_rw_d   = 1'b0;
        ex_mr_d   = 1'b0;
        mem_dst_d = ex_dst_q;
        mem_rw_d  = ex_rw_q;
        sel_a_d   = SEL_RF;
        sel_b_d   = SEL_RF;

        // Load in EX feeding the ID instruction: the data only exists after
        // MEM, so the consumer must wait one cycle. A flushed instruction
        // never stalls. In STALL, EX always holds the inserted bubble.
        if ((state_q == ST_RUN) && IdValid && !Flush && ex_mr_q &&
            (ex_dst_q != REG_ZERO) &&
            ((ex_dst_q == IdRs) || (ex_dst_q == IdRt))) begin
            stall = 1'b1;
        end

        // Anything that does not really issue enters EX as an all-zero bubble
        // and uses no forwarding.
        id_bubble = !IdValid || Flush || stall;

        if (!id_bubble) begin
            ex_dst_d = IdDst;
            ex_rw_d  = IdRegWrite;
            ex_mr_d  = IdMemRead;
            sel_a_d  = fwd_sel(ex_rw_q, ex_dst_q, mem_rw_q, mem_dst_q, IdRs);
            sel_b_d  = fwd_sel(ex_rw_q, ex_dst_q, mem_rw_q, mem_dst_q, IdRt);
        end

        unique case (state_q)
            ST_RUN:   if (stall) state_d = ST_STALL;
            ST_STALL: state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    // Pipeline registers: shadow stages, registered selects and FSM state.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q   <= ST_RUN;
            ex_dst_q  <= '0;
            ex_rw_q   <= 1'b0;
            ex_mr_q   <= 1'b0;
            mem_dst_q <= '0;
            mem_rw_q  <= 1'b0;
            sel_a_q   <= SEL_RF;
            sel_b_q   <= SEL_RF;
        end else begin
            // NOTE: non-blocking assignments make every register sample the
            //       pre-edge values, so mem_* takes the old ex_* contents and
            //       not the ones loaded on this same edge.
            state_q   <= state_d;
            ex_dst_q  <= ex_dst_d;
            ex_rw_q   <= ex_rw_d;
            ex_mr_q   <= ex_mr_d;
            mem_dst_q <= mem_dst_d;
            mem_rw_q  <= mem_rw_d;
            sel_a_q   <= sel_a_d;
            sel_b_q   <= sel_b_d;
        end
    end

`ifdef FWD_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    // Saturating count of stall cycles since reset.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign StallCnt = stall_cnt_q;
`endif

    assign SelA  = sel_a_q;
    assign SelB  = sel_b_q;
    assign Stall = stall;

endmodule
